subtractor_8bit_serial: RTL and testbench

- Bit-serial, multi-cycle inverse of the combinational ripple adder chain.
- Computes A - B - borrow-in one bit per clock, LSB first, using a single full-subtractor cell plus shift registers.
- Valid/ready on both sides, so it can sit between register stages in the testing datapath where area matters more than latency.
- Also produces borrow, zero and signed-overflow flags.

---
 rtl/subtractor_8bit_serial.sv | 176 +++++++++++++++++
 tb/tb_subtractor_8bit_serial.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subtractor_8bit_serial.sv
// subtractor_8bit_serial
//
// Bit-serial subtractor that computes inA - inB - inBorrow one bit per clock,
// LSB first, with a single full-subtractor cell. Operands sit in right-shifting
// registers, and each new difference bit enters at the top of the difference
// register. After WIDTH shift cycles the result and its flags are registered
// and presented with a valid/ready handshake.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous assert, synchronous release, active-low reset
//   inValid      upstream presents an operand set
//   outReady     block can accept operands (high only in IDLE)
//   inA, inB     minuend and subtrahend, WIDTH bits
//   inBorrow     borrow-in
//   outValid     result available (high only in DONE)
//   inReady      downstream accepts the result
//   outDiff      (inA - inB - inBorrow) mod 2^WIDTH
//   outBorrow    unsigned borrow-out
//   outZero      outDiff is zero
//   outOverflow  signed two's-complement overflow
//
// Results and flags persist after the output handshake. They change only when
// the next operation completes or when reset is applied.

module subtractor_8bit_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inValid,
  output logic             outReady,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             inBorrow,
  output logic             outValid,
  input  logic             inReady,
  output logic [WIDTH-1:0] outDiff,
  output logic             outBorrow,
  output logic             outZero,
  output logic             outOverflow
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t r_state;
  state_t w_nextState;

  // Operand shift registers. Bit 0 is always the bit that is processed next.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  // Holds only the upper WIDTH-1 bits of the partial difference. The bit
  // produced in the current cycle completes the full WIDTH-bit word, so the
  // finished result needs no extra shift.
  logic [WIDTH-2:0] r_diff;

  logic             r_br;
  logic [CNT_W-1:0] r_cnt;

  // The shift registers destroy the operand MSBs, so the overflow rule uses
  // copies latched on the accept edge.
  logic             r_aMsb;
  logic             r_bMsb;

  logic [WIDTH-1:0] r_outDiff;
  logic             r_outBorrow;
  logic             r_outZero;
  logic             r_outOverflow;

  logic             w_accept;
  logic             w_lastBit;
  logic             w_d;
  logic             w_brNext;
  logic [WIDTH-1:0] w_finalDiff;

  // Single full-subtractor cell working on the current LSBs.
  assign w_d         = r_a[0] ^ r_b[0] ^ r_br;
  assign w_brNext    = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
  assign w_finalDiff = {w_d, r_diff};

  assign w_accept  = inValid && (r_state == ST_IDLE);
  assign w_lastBit = (r_state == ST_SHIFT) && (r_cnt == LAST_BIT);

  // State register. Reset parks the FSM in IDLE, so outReady is high
  // throughout reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and handshake outputs. Both handshake outputs are pure
  // state decodes, so they cannot glitch on input activity.
  always_comb begin
    w_nextState = r_state;
    outReady    = 1'b0;
    outValid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        outReady = 1'b1;
        if (inValid) begin
          w_nextState = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == LAST_BIT) begin
          w_nextState = ST_DONE;
        end
      end
      ST_DONE: begin
        outValid = 1'b1;
        if (inReady) begin
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Datapath. The accept edge loads the operands. Each SHIFT edge consumes one
  // bit. The final SHIFT edge also registers the result and flags, so they
  // become visible exactly when the FSM enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a           <= '0;
      r_b           <= '0;
      r_diff        <= '0;
      r_br          <= 1'b0;
      r_cnt         <= '0;
      r_aMsb        <= 1'b0;
      r_bMsb        <= 1'b0;
      r_outDiff     <= '0;
      r_outBorrow   <= 1'b0;
      r_outZero     <= 1'b0;
      r_outOverflow <= 1'b0;
    end else if (w_accept) begin
      r_a    <= inA;
      r_b    <= inB;
      r_br   <= inBorrow;
      r_aMsb <= inA[WIDTH-1];
      r_bMsb <= inB[WIDTH-1];
      r_cnt  <= '0;
      r_diff <= '0;
    end else if (r_state == ST_SHIFT) begin
      r_a    <= r_a >> 1;
      r_b    <= r_b >> 1;
      r_br   <= w_brNext;
      r_diff <= w_finalDiff[WIDTH-1:1];
      r_cnt  <= r_cnt + CNT_W'(1);
      if (w_lastBit) begin
        r_outDiff     <= w_finalDiff;
        r_outBorrow   <= w_brNext;
        r_outZero     <= (w_finalDiff == '0);
        r_outOverflow <= (r_aMsb != r_bMsb) && (w_finalDiff[WIDTH-1] != r_aMsb);
      end
    end
  end

  assign outDiff     = r_outDiff;
  assign outBorrow   = r_outBorrow;
  assign outZero     = r_outZero;
  assign outOverflow = r_outOverflow;

endmodule

// File: tb/tb_subtractor_8bit_serial.sv
// tb_subtractor_8bit_serial
//
// Self-checking bench for the bit-serial subtractor. It drives an 8-bit
// instance through a table of directed vectors, the backpressure, mid-operation
// reset and back-to-back sequences, and a set of randomized operations. A 4-bit
// instance checks the parameterised width. Expected values come from constants
// or from an arithmetic reference model.

module tb_subtractor_8bit_serial;

  logic       clk;
  logic       rst_n;
  logic       inValid;
  logic       outReady;
  logic [7:0] inA;
  logic [7:0] inB;
  logic       inBorrow;
  logic       outValid;
  logic       inReady;
  logic [7:0] outDiff;
  logic       outBorrow;
  logic       outZero;
  logic       outOverflow;

  logic       smallInValid;
  logic       smallOutReady;
  logic [3:0] smallInA;
  logic [3:0] smallInB;
  logic       smallInBorrow;
  logic       smallOutValid;
  logic       smallInReady;
  logic [3:0] smallOutDiff;
  logic       smallOutBorrow;
  logic       smallOutZero;
  logic       smallOutOverflow;

  int assertCount = 0;
  int failCount   = 0;
  int cycleNum    = 0;

  int         acceptQ[$];
  logic [7:0] resDiffQ[$];
  logic       resBorrowQ[$];

  typedef struct {
    logic [7:0] diff;
    logic       borrow;
    logic       zero;
    logic       ovf;
  } result_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] expDiff;
    logic       expBorrow;
    logic       expZero;
    logic       expOvf;
    int         hold;
  } vector_t;

  vector_t vecs[10];

  subtractor_8bit_serial #(.WIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .inValid(inValid),
    .outReady(outReady),
    .inA(inA),
    .inB(inB),
    .inBorrow(inBorrow),
    .outValid(outValid),
    .inReady(inReady),
    .outDiff(outDiff),
    .outBorrow(outBorrow),
    .outZero(outZero),
    .outOverflow(outOverflow)
  );

  subtractor_8bit_serial #(.WIDTH(4)) dutSmall (
    .clk(clk),
    .rst_n(rst_n),
    .inValid(smallInValid),
    .outReady(smallOutReady),
    .inA(smallInA),
    .inB(smallInB),
    .inBorrow(smallInBorrow),
    .outValid(smallOutValid),
    .inReady(smallInReady),
    .outDiff(smallOutDiff),
    .outBorrow(smallOutBorrow),
    .outZero(smallOutZero),
    .outOverflow(smallOutOverflow)
  );

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Records accept edges and completed output handshakes of the 8-bit
  // instance, timestamped by cycle, for the back-to-back sequence.
  always @(posedge clk) begin
    if (inValid && outReady) acceptQ.push_back(cycleNum);
    if (outValid && inReady) begin
      resDiffQ.push_back(outDiff);
      resBorrowQ.push_back(outBorrow);
    end
    cycleNum++;
  end

  // Reference model. It computes the subtraction as plain integer arithmetic:
  // the borrow is a negative true result, and the overflow rule compares sign
  // bits of the operands and the result.
  function automatic result_t refModel(input int w, input int a, input int b, input int bin);
    result_t r;
    int full;
    int diffInt;
    int aMsb;
    int bMsb;
    int dMsb;
    full    = a - b - bin;
    diffInt = full & ((1 << w) - 1);
    aMsb    = (a >> (w - 1)) & 1;
    bMsb    = (b >> (w - 1)) & 1;
    dMsb    = (diffInt >> (w - 1)) & 1;
    r.diff   = 8'(diffInt);
    r.borrow = (full < 0);
    r.zero   = (diffInt == 0);
    r.ovf    = (aMsb != bMsb) && (dMsb != aMsb);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Waits for outReady, presents one operand set, scrambles the inputs after
  // the accept edge, and waits until outValid rises. Returns at 1 ns after the
  // edge that raised outValid.
  task automatic startAndWait(input logic [7:0] a, input logic [7:0] b, input logic bin, input string tag);
    int guard;
    int lat;
    guard = 0;
    while (outReady !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput({tag, " ready before accept"}, 32'(outReady), 1);
    inA      = a;
    inB      = b;
    inBorrow = bin;
    inValid  = 1'b1;
    @(posedge clk); #1;
    inValid  = 1'b0;
    inA      = ~a;
    inB      = ~b;
    inBorrow = ~bin;
    checkOutput({tag, " ready low after accept"}, 32'(outReady), 0);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (outValid !== 1'b1 && lat < 100);
    checkOutput({tag, " latency"}, lat, 8);
  endtask

  // Performs one full operation: accept, result checks, an optional stall with
  // inReady low, then the output handshake and the persistence checks.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic bin,
                               input int hold, input logic [7:0] expDiff, input logic expBorrow,
                               input logic expZero, input logic expOvf, input string tag);
    startAndWait(a, b, bin, tag);
    checkOutput({tag, " diff"}, 32'(outDiff), 32'(expDiff));
    checkOutput({tag, " borrow"}, 32'(outBorrow), 32'(expBorrow));
    checkOutput({tag, " zero"}, 32'(outZero), 32'(expZero));
    checkOutput({tag, " overflow"}, 32'(outOverflow), 32'(expOvf));
    repeat (hold) begin
      @(posedge clk); #1;
      checkOutput({tag, " stall valid"}, 32'(outValid), 1);
      checkOutput({tag, " stall diff"}, 32'(outDiff), 32'(expDiff));
    end
    inReady = 1'b1;
    @(posedge clk); #1;
    inReady = 1'b0;
    checkOutput({tag, " valid falls"}, 32'(outValid), 0);
    checkOutput({tag, " ready rises"}, 32'(outReady), 1);
    checkOutput({tag, " diff persists"}, 32'(outDiff), 32'(expDiff));
  endtask

  // Runs one operation on the 4-bit instance.
  task automatic runWidth4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                           input logic [3:0] expDiff, input logic expBorrow, input logic expZero,
                           input logic expOvf, input string tag);
    int guard;
    int lat;
    guard = 0;
    while (smallOutReady !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput({tag, " ready before accept"}, 32'(smallOutReady), 1);
    smallInA      = a;
    smallInB      = b;
    smallInBorrow = bin;
    smallInValid  = 1'b1;
    @(posedge clk); #1;
    smallInValid  = 1'b0;
    smallInA      = ~a;
    smallInB      = ~b;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (smallOutValid !== 1'b1 && lat < 100);
    checkOutput({tag, " latency"}, lat, 4);
    checkOutput({tag, " diff"}, 32'(smallOutDiff), 32'(expDiff));
    checkOutput({tag, " borrow"}, 32'(smallOutBorrow), 32'(expBorrow));
    checkOutput({tag, " zero"}, 32'(smallOutZero), 32'(expZero));
    checkOutput({tag, " overflow"}, 32'(smallOutOverflow), 32'(expOvf));
    smallInReady = 1'b1;
    @(posedge clk); #1;
    smallInReady = 1'b0;
    checkOutput({tag, " valid falls"}, 32'(smallOutValid), 0);
    checkOutput({tag, " ready rises"}, 32'(smallOutReady), 1);
  endtask

  // Main test sequence.
  initial begin
    int      guard;
    int      lat;
    int      spurious;
    result_t r;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rbin;
    logic [3:0] sa;
    logic [3:0] sb;

    vecs[0] = '{8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1, 2};
    vecs[4] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 0};
    vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1, 1};
    vecs[6] = '{8'h03, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 0};
    vecs[7] = '{8'h01, 8'h03, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, 0};
    vecs[8] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 3};
    vecs[9] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 0};

    rst_n         = 1'b0;
    inValid       = 1'b0;
    inA           = '0;
    inB           = '0;
    inBorrow      = 1'b0;
    inReady       = 1'b0;
    smallInValid  = 1'b0;
    smallInA      = '0;
    smallInB      = '0;
    smallInBorrow = 1'b0;
    smallInReady  = 1'b0;

    #12;
    checkOutput("reset outReady", 32'(outReady), 1);
    checkOutput("reset outValid", 32'(outValid), 0);
    checkOutput("reset outDiff", 32'(outDiff), 0);
    checkOutput("reset outBorrow", 32'(outBorrow), 0);
    checkOutput("reset outZero", 32'(outZero), 0);
    checkOutput("reset outOverflow", 32'(outOverflow), 0);
    checkOutput("reset small outReady", 32'(smallOutReady), 1);
    checkOutput("reset small outValid", 32'(smallOutValid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].hold, vecs[i].expDiff,
                    vecs[i].expBorrow, vecs[i].expZero, vecs[i].expOvf, $sformatf("vec%0d", i));
    end

    // Backpressure: stall for five cycles while a new request is pending, then
    // release. The pending request must wait until the FSM is back in IDLE.
    $display("[TB] backpressure");
    startAndWait(8'h50, 8'h20, 1'b0, "bp");
    inA      = 8'h11;
    inB      = 8'h01;
    inBorrow = 1'b0;
    inValid  = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      checkOutput("bp stall valid", 32'(outValid), 1);
      checkOutput("bp stall diff", 32'(outDiff), 'h30);
      checkOutput("bp stall ready", 32'(outReady), 0);
      checkOutput("bp stall flags", 32'({outBorrow, outZero, outOverflow}), 0);
    end
    inReady = 1'b1;
    @(posedge clk); #1;
    inReady = 1'b0;
    checkOutput("bp valid falls", 32'(outValid), 0);
    checkOutput("bp ready rises", 32'(outReady), 1);
    @(posedge clk); #1;
    inValid = 1'b0;
    checkOutput("bp pending accepted", 32'(outReady), 0);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (outValid !== 1'b1 && lat < 100);
    checkOutput("bp second latency", lat, 8);
    checkOutput("bp second diff", 32'(outDiff), 'h10);
    inReady = 1'b1;
    @(posedge clk); #1;
    inReady = 1'b0;

    // Reset three cycles into SHIFT. All outputs clear at once, and no partial
    // result appears after release.
    $display("[TB] reset mid-operation");
    inA      = 8'h50;
    inB      = 8'h20;
    inBorrow = 1'b0;
    inValid  = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst outReady", 32'(outReady), 1);
    checkOutput("midrst outValid", 32'(outValid), 0);
    checkOutput("midrst outDiff", 32'(outDiff), 0);
    checkOutput("midrst flags", 32'({outBorrow, outZero, outOverflow}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    spurious = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (outValid !== 1'b0) spurious++;
    end
    checkOutput("midrst no partial result", spurious, 0);
    applyStimulus(8'hAA, 8'h55, 1'b0, 0, 8'h55, 1'b0, 1'b0, 1'b1, "postrst");

    // Back-to-back: inValid and inReady held high continuously.
    $display("[TB] back-to-back");
    acceptQ.delete();
    resDiffQ.delete();
    resBorrowQ.delete();
    inA      = 8'h03;
    inB      = 8'h01;
    inBorrow = 1'b0;
    inReady  = 1'b1;
    inValid  = 1'b1;
    guard = 0;
    while (acceptQ.size() < 1 && guard < 30) begin
      @(posedge clk); #1;
      guard++;
    end
    inA = 8'h01;
    inB = 8'h03;
    guard = 0;
    while (acceptQ.size() < 2 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    inValid = 1'b0;
    guard = 0;
    while (resDiffQ.size() < 2 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    inReady = 1'b0;
    checkOutput("b2b accept count", acceptQ.size(), 2);
    checkOutput("b2b result count", resDiffQ.size(), 2);
    if (acceptQ.size() >= 2) checkOutput("b2b accept spacing", acceptQ[1] - acceptQ[0], 10);
    if (resDiffQ.size() >= 2) begin
      checkOutput("b2b first diff", 32'(resDiffQ[0]), 'h02);
      checkOutput("b2b first borrow", 32'(resBorrowQ[0]), 0);
      checkOutput("b2b second diff", 32'(resDiffQ[1]), 'hFE);
      checkOutput("b2b second borrow", 32'(resBorrowQ[1]), 1);
    end

    // Width 4 instance: one directed case, then randomized cases.
    $display("[TB] width 4");
    runWidth4(4'h3, 4'h5, 1'b0, 4'hE, 1'b1, 1'b0, 1'b0, "w4 3-5");
    for (int i = 0; i < 8; i++) begin
      sa   = 4'($urandom);
      sb   = 4'($urandom);
      rbin = 1'($urandom);
      r = refModel(4, int'(sa), int'(sb), int'(rbin));
      runWidth4(sa, sb, rbin, r.diff[3:0], r.borrow, r.zero, r.ovf, $sformatf("w4 rand%0d", i));
    end

    // Randomized 8-bit operations against the reference model.
    $display("[TB] randomized");
    for (int i = 0; i < 30; i++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rbin = 1'($urandom);
      r = refModel(8, int'(ra), int'(rb), int'(rbin));
      applyStimulus(ra, rb, rbin, int'($urandom_range(0, 3)), r.diff, r.borrow, r.zero, r.ovf,
                    $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  // Safety net in case the sequence itself stops making progress.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
